// File: rtl/meta_array_ctrl.sv
// Controller for a 128x30 metadata array: clearing sweep, single write port, two round-robin readers.
// Define META_CTRL_INIT_SWEEP_EN to run the clearing sweep automatically when reset is released.
module meta_array_ctrl #(
  parameter logic [29:0] INIT_DATA = 30'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rd0_valid,
  input  logic [6:0]  rd0_addr,
  output logic        rd0_ready,
  input  logic        rd1_valid,
  input  logic [6:0]  rd1_addr,
  output logic        rd1_ready,
  input  logic        wr_valid,
  input  logic [6:0]  wr_addr,
  input  logic [29:0] wr_data,
  output logic        wr_ready,
  input  logic        flush_valid,
  output logic        flush_ready,
  output logic        sweep_done,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [29:0] rsp_data,
  output logic [6:0]  mem_R0_addr,
  output logic        mem_R0_en,
  input  logic [29:0] mem_R0_data,
  output logic [6:0]  mem_W0_addr,
  output logic        mem_W0_en,
  output logic [29:0] mem_W0_data
);

  typedef enum logic {SWEEP = 1'b0, IDLE = 1'b1} state_e;

`ifdef META_CTRL_INIT_SWEEP_EN
  localparam state_e RESET_STATE = SWEEP;
`else
  localparam state_e RESET_STATE = IDLE;
`endif

  state_e     state_q, state_d;
  logic [6:0] sweepCnt_q, sweepCnt_d;
  logic       lastGrant_q, lastGrant_d;
  logic       rspValid_q, rspValid_d;
  logic       rspId_q, rspId_d;
  logic       grant0, grant1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      sweepCnt_q  <= 7'd0;
      lastGrant_q <= 1'b1;
      rspValid_q  <= 1'b0;
      rspId_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweepCnt_q  <= sweepCnt_d;
      lastGrant_q <= lastGrant_d;
      rspValid_q  <= rspValid_d;
      rspId_q     <= rspId_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweepCnt_d  = sweepCnt_q;
    lastGrant_d = lastGrant_q;
    grant0      = 1'b0;
    grant1      = 1'b0;
    wr_ready    = 1'b0;
    flush_ready = 1'b0;
    sweep_done  = 1'b0;
    mem_R0_en   = 1'b0;
    mem_R0_addr = 7'd0;
    mem_W0_en   = 1'b0;
    mem_W0_addr = 7'd0;
    mem_W0_data = 30'd0;
    case (state_q)
      SWEEP: begin
        mem_W0_en   = 1'b1;
        mem_W0_addr = sweepCnt_q;
        mem_W0_data = INIT_DATA;
        if (sweepCnt_q == 7'd127) begin
          sweep_done = 1'b1;
          state_d    = IDLE;
          sweepCnt_d = 7'd0;
        end else begin
          sweepCnt_d = sweepCnt_q + 7'd1;
        end
      end
      IDLE: begin
        wr_ready    = 1'b1;
        flush_ready = 1'b1;
        // lastGrant_q==1 means rd1 won the previous grant, so rd0 wins a tie
        grant0 = rd0_valid && (!rd1_valid || lastGrant_q);
        grant1 = rd1_valid && (!rd0_valid || !lastGrant_q);
        if (grant0) begin
          mem_R0_en   = 1'b1;
          mem_R0_addr = rd0_addr;
          lastGrant_d = 1'b0;
        end else if (grant1) begin
          mem_R0_en   = 1'b1;
          mem_R0_addr = rd1_addr;
          lastGrant_d = 1'b1;
        end
        if (wr_valid) begin
          mem_W0_en   = 1'b1;
          mem_W0_addr = wr_addr;
          mem_W0_data = wr_data;
        end
        if (flush_valid) begin
          state_d    = SWEEP;
          sweepCnt_d = 7'd0;
        end
      end
      default: ;
    endcase
    rd0_ready  = grant0;
    rd1_ready  = grant1;
    rspValid_d = grant0 || grant1;
    rspId_d    = (grant0 || grant1) ? grant1 : rspId_q;
  end

  // Same-address write/read returns new data purely through the array's edge timing
  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign rsp_data  = rspValid_q ? mem_R0_data : 30'd0;

endmodule
